// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
//
// Control end of the 8-bit bus datapath: three GGREG8 registers sharing a
// tri-state operand bus, plus ADD8/MUL8 units whose B operand is a constant
// load. One register-to-register instruction is taken in IDLE. The block then
// sequences every enable: operand-bus driver, result-bus unit, carry-in and the
// destination load pulse. It finishes with a one-cycle done (and err for an
// illegal instruction).
//
// Sequence: IDLE -> SRC -> EXEC (W cycles) -> WB -> DONE -> IDLE
//           IDLE -> DONE directly for an illegal op/src/dst.
//
// Ports
//   CK        in   1  clock, rising edge
//   Clear     in   1  synchronous active-high reset, overrides start
//   start     in   1  instruction valid, sampled only in IDLE
//   op        in   2  00 ADD, 01 MUL, 10 ADDC (carry-in=1), 11 illegal
//   src       in   2  operand register 0..2 (3 illegal)
//   dst       in   2  destination register 0..2 (3 illegal)
//   bus_oe    out  3  one-hot operand-bus driver enable for R0..R2
//   reg_ld    out  3  one-hot single-cycle load pulse for R0..R2
//   add_oe    out  1  adder result-bus buffer enable
//   mul_oe    out  1  multiplier result-bus buffer enable
//   carry_in  out  1  adder carry input
//   busy      out  1  high in every state except IDLE
//   done      out  1  one-cycle completion pulse
//   err       out  1  one-cycle pulse with done for an illegal instruction
//   op_count  out  8  completed legal instructions, wraps 255->0
//
// Every output is a flop. Its next value is decoded from the next state and
// the next latched instruction fields. This keeps the enables glitch-free on
// the tri-state bus and lets Clear drop them all at the same edge.
// -----------------------------------------------------------------------------
module datapath_sequencer #(
   parameter int unsigned ADD_WAIT = 32'd1,   // EXEC cycles for ADD/ADDC, 1..15
   parameter int unsigned MUL_WAIT = 32'd3    // EXEC cycles for MUL, 1..15
) (
   input  logic       CK,
   input  logic       Clear,
   input  logic       start,
   input  logic [1:0] op,
   input  logic [1:0] src,
   input  logic [1:0] dst,
   output logic [2:0] bus_oe,
   output logic [2:0] reg_ld,
   output logic       add_oe,
   output logic       mul_oe,
   output logic       carry_in,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] op_count
);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_MUL  = 2'b01;
   localparam logic [1:0] OP_ADDC = 2'b10;
   localparam logic [1:0] OP_BAD  = 2'b11;
   localparam logic [1:0] REG_BAD = 2'd3;

   localparam logic [3:0] ADD_W_C = ADD_WAIT[3:0];
   localparam logic [3:0] MUL_W_C = MUL_WAIT[3:0];

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SRC  = 3'd1,
      ST_EXEC = 3'd2,
      ST_WB   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Register index to one-hot enable; index 3 gives no enable at all.
   function automatic logic [2:0] decode3(input logic [1:0] idx);
      logic [2:0] oh;
      case (idx)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

   // An instruction is legal only if op, src and dst are all in range.
   function automatic logic is_legal(input logic [1:0] o, input logic [1:0] s,
                                     input logic [1:0] d);
      return (o != OP_BAD) && (s != REG_BAD) && (d != REG_BAD);
   endfunction

   state_t      state_r,   state_nx_s;
   logic [1:0]  op_r,      op_nx_s;
   logic [1:0]  src_r,     src_nx_s;
   logic [1:0]  dst_r,     dst_nx_s;
   logic        ill_r,     ill_nx_s;
   logic [3:0]  cnt_r,     cnt_nx_s;

   logic [2:0]  bus_oe_r,  bus_oe_nx_s;
   logic [2:0]  reg_ld_r,  reg_ld_nx_s;
   logic        add_oe_r,  add_oe_nx_s;
   logic        mul_oe_r,  mul_oe_nx_s;
   logic        carry_r,   carry_nx_s;
   logic        busy_r,    busy_nx_s;
   logic        done_r,    done_nx_s;
   logic        err_r,     err_nx_s;
   logic [7:0]  count_r,   count_nx_s;

   // Next-state logic and instruction latch; fields change only on an IDLE start.
   always_comb begin
      state_nx_s = state_r;
      op_nx_s    = op_r;
      src_nx_s   = src_r;
      dst_nx_s   = dst_r;
      ill_nx_s   = ill_r;
      cnt_nx_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               op_nx_s    = op;
               src_nx_s   = src;
               dst_nx_s   = dst;
               ill_nx_s   = ~is_legal(op, src, dst);
               state_nx_s = is_legal(op, src, dst) ? ST_SRC : ST_DONE;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SRC: begin
            cnt_nx_s   = (op_r == OP_MUL) ? MUL_W_C : ADD_W_C;
            state_nx_s = ST_EXEC;
         end
         ST_EXEC: begin
            // The count was loaded with W, so EXEC lasts exactly W cycles.
            if (cnt_r <= 4'd1) begin
               state_nx_s = ST_WB;
            end else begin
               cnt_nx_s   = cnt_r - 4'd1;
               state_nx_s = ST_EXEC;
            end
         end
         ST_WB: begin
            state_nx_s = ST_DONE;
         end
         ST_DONE: begin
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state so every output can be a flop.
   always_comb begin
      bus_oe_nx_s = 3'b000;
      reg_ld_nx_s = 3'b000;
      add_oe_nx_s = 1'b0;
      mul_oe_nx_s = 1'b0;
      carry_nx_s  = 1'b0;
      done_nx_s   = 1'b0;
      err_nx_s    = 1'b0;
      count_nx_s  = count_r;
      busy_nx_s   = (state_nx_s != ST_IDLE);
      case (state_nx_s)
         ST_IDLE: begin
            bus_oe_nx_s = 3'b000;
         end
         ST_SRC: begin
            bus_oe_nx_s = decode3(src_nx_s);
         end
         ST_EXEC: begin
            bus_oe_nx_s = decode3(src_nx_s);
            add_oe_nx_s = (op_nx_s == OP_ADD) || (op_nx_s == OP_ADDC);
            mul_oe_nx_s = (op_nx_s == OP_MUL);
            carry_nx_s  = (op_nx_s == OP_ADDC);
         end
         ST_WB: begin
            bus_oe_nx_s = decode3(src_nx_s);
            add_oe_nx_s = (op_nx_s == OP_ADD) || (op_nx_s == OP_ADDC);
            mul_oe_nx_s = (op_nx_s == OP_MUL);
            carry_nx_s  = (op_nx_s == OP_ADDC);
            reg_ld_nx_s = decode3(dst_nx_s);
         end
         ST_DONE: begin
            done_nx_s  = 1'b1;
            err_nx_s   = ill_nx_s;
            // DONE is entered once per instruction, so the count is visible
            // in the same cycle as the done pulse.
            count_nx_s = ill_nx_s ? count_r : (count_r + 8'd1);
         end
         default: begin
            bus_oe_nx_s = 3'b000;
         end
      endcase
   end

   // State, instruction latch and output registers; Clear drops everything at one edge.
   always_ff @(posedge CK) begin
      if (Clear) begin
         state_r  <= ST_IDLE;
         op_r     <= 2'b00;
         src_r    <= 2'b00;
         dst_r    <= 2'b00;
         ill_r    <= 1'b0;
         cnt_r    <= 4'd0;
         bus_oe_r <= 3'b000;
         reg_ld_r <= 3'b000;
         add_oe_r <= 1'b0;
         mul_oe_r <= 1'b0;
         carry_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
         count_r  <= 8'd0;
      end else begin
         state_r  <= state_nx_s;
         op_r     <= op_nx_s;
         src_r    <= src_nx_s;
         dst_r    <= dst_nx_s;
         ill_r    <= ill_nx_s;
         cnt_r    <= cnt_nx_s;
         bus_oe_r <= bus_oe_nx_s;
         reg_ld_r <= reg_ld_nx_s;
         add_oe_r <= add_oe_nx_s;
         mul_oe_r <= mul_oe_nx_s;
         carry_r  <= carry_nx_s;
         busy_r   <= busy_nx_s;
         done_r   <= done_nx_s;
         err_r    <= err_nx_s;
         count_r  <= count_nx_s;
      end
   end

   assign bus_oe   = bus_oe_r;
   assign reg_ld   = reg_ld_r;
   assign add_oe   = add_oe_r;
   assign mul_oe   = mul_oe_r;
   assign carry_in = carry_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign err      = err_r;
   assign op_count = count_r;

endmodule

// File: tb/tb_datapath_sequencer.sv
// -----------------------------------------------------------------------------
// tb_datapath_sequencer
//
// Scoreboard bench for datapath_sequencer. The driver issues instructions at
// edges it knows the sequencer will sample. For each one it pushes a record
// (sampling edge, op, src, dst) into a queue. A monitor on the falling edge
// turns the front record into the expected enables for the current cycle. It
// uses an instruction timeline: SRC, then W EXEC cycles, then WB and DONE.
// It compares those enables with the outputs, keeps its own completed-
// instruction count and checks the bus invariants every cycle.
// -----------------------------------------------------------------------------
module tb_datapath_sequencer;

   localparam int ADD_W = 1;
   localparam int MUL_W = 3;

   logic       CK = 1'b0;
   logic       Clear;
   logic       start;
   logic [1:0] op, src, dst;
   logic [2:0] bus_oe, reg_ld;
   logic       add_oe, mul_oe, carry_in, busy, done, err;
   logic [7:0] op_count;

   datapath_sequencer #(.ADD_WAIT(ADD_W), .MUL_WAIT(MUL_W)) dut (
      .CK(CK), .Clear(Clear), .start(start), .op(op), .src(src), .dst(dst),
      .bus_oe(bus_oe), .reg_ld(reg_ld), .add_oe(add_oe), .mul_oe(mul_oe),
      .carry_in(carry_in), .busy(busy), .done(done), .err(err),
      .op_count(op_count)
   );

   always #5 CK = ~CK;

   typedef struct {
      int         e;       // index of the rising edge that samples start
      logic [1:0] op;
      logic [1:0] src;
      logic [1:0] dst;
      bit         legal;
   } item_t;

   item_t      q[$];
   int         edges = 0;
   bit         clr_q = 1'b0;
   int         next_free = 0;
   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_count = 8'd0;
   int         legal_after_clear = 0;

   // Edge counter and registered view of Clear for the monitor.
   always @(posedge CK) begin
      edges <= edges + 1;
      clr_q <= Clear;
   end

   function automatic logic [2:0] oh(input logic [1:0] i);
      logic [2:0] r;
      r = 3'b000;
      if (i != 2'd3) r[i] = 1'b1;
      return r;
   endfunction

   function automatic int wait_of(input logic [1:0] o);
      return (o == 2'b01) ? MUL_W : ADD_W;
   endfunction

   // Monitor: build expected outputs from the instruction timeline and compare.
   always @(negedge CK) begin
      logic [2:0] e_bus, e_ld;
      logic       e_add, e_mul, e_cy, e_busy, e_done, e_err;
      bit         in_done;
      int         k, w;
      item_t      it;
      e_bus = 3'b000; e_ld = 3'b000;
      e_add = 1'b0; e_mul = 1'b0; e_cy = 1'b0;
      e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      in_done = 1'b0;
      if (clr_q) begin
         exp_count = 8'd0;
         if (q.size() > 0 && q[0].e <= edges) void'(q.pop_front());
      end else if (q.size() > 0 && q[0].e <= edges) begin
         it = q[0];
         k  = edges - it.e;
         w  = wait_of(it.op);
         e_busy = 1'b1;
         if (!it.legal) begin
            e_done = 1'b1; e_err = 1'b1; in_done = 1'b1;
            void'(q.pop_front());
         end else if (k == 0) begin
            e_bus = oh(it.src);
         end else if (k <= w + 1) begin
            e_bus = oh(it.src);
            e_add = (it.op != 2'b01);
            e_mul = (it.op == 2'b01);
            e_cy  = (it.op == 2'b10);
            if (k == w + 1) e_ld = oh(it.dst);
         end else begin
            e_done = 1'b1; in_done = 1'b1;
            exp_count = exp_count + 8'd1;
            void'(q.pop_front());
         end
      end
      checks++;
      if ({bus_oe, reg_ld, add_oe, mul_oe, carry_in, busy, done, err} !==
          {e_bus, e_ld, e_add, e_mul, e_cy, e_busy, e_done, e_err}) begin
         failures++;
         $display("FAIL outputs edge=%0d got bus=%b ld=%b add=%b mul=%b cy=%b busy=%b done=%b err=%b want bus=%b ld=%b add=%b mul=%b cy=%b busy=%b done=%b err=%b",
                  edges, bus_oe, reg_ld, add_oe, mul_oe, carry_in, busy, done, err,
                  e_bus, e_ld, e_add, e_mul, e_cy, e_busy, e_done, e_err);
      end
      // The count's update cycle is the done cycle itself; compare it everywhere else.
      if (!in_done) begin
         checks++;
         if (op_count !== exp_count) begin
            failures++;
            $display("FAIL op_count edge=%0d got %0d want %0d", edges, op_count, exp_count);
         end
      end
      checks++;
      if (!$onehot0(bus_oe) || !$onehot0(reg_ld) || (add_oe && mul_oe)) begin
         failures++;
         $display("FAIL invariant edge=%0d bus_oe=%b reg_ld=%b add_oe=%b mul_oe=%b required one-hot/exclusive",
                  edges, bus_oe, reg_ld, add_oe, mul_oe);
      end
   end

   // Issue one instruction at the first edge the sequencer can sample it.
   // While busy, inputs are scrambled (start held high if requested).
   task automatic issue(input logic [1:0] o, input logic [1:0] s,
                        input logic [1:0] d, input bit held);
      item_t it;
      while (edges + 1 < next_free) begin
         start = held ? 1'b1 : 1'($urandom_range(0, 1));
         op = 2'($urandom); src = 2'($urandom); dst = 2'($urandom);
         @(posedge CK); #1;
      end
      start = 1'b1; op = o; src = s; dst = d;
      it.e = edges + 1; it.op = o; it.src = s; it.dst = d;
      it.legal = (o != 2'd3) && (s != 2'd3) && (d != 2'd3);
      q.push_back(it);
      next_free = it.e + (it.legal ? wait_of(o) + 4 : 2);
      @(posedge CK); #1;
      start = held ? 1'b1 : 1'b0;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         start = 1'b0;
         op = 2'($urandom); src = 2'($urandom); dst = 2'($urandom);
         @(posedge CK); #1;
      end
   endtask

   initial begin
      logic [1:0] ro, rs, rd;
      int guard;
      Clear = 1'b1; start = 1'b0; op = 2'b00; src = 2'b00; dst = 2'b00;
      // T1 reset
      repeat (2) @(posedge CK);
      #1 Clear = 1'b0;
      next_free = edges + 1;
      // T2 ADD r1 -> r2, T3 MUL r0 -> r0
      issue(2'b00, 2'd1, 2'd2, 1'b0);
      gap(8);
      issue(2'b01, 2'd0, 2'd0, 1'b0);
      gap(10);
      // T4 illegal op, src, dst
      issue(2'b11, 2'd0, 2'd1, 1'b0);
      gap(2);
      issue(2'b00, 2'd3, 2'd1, 1'b0);
      issue(2'b01, 2'd1, 2'd3, 1'b0);
      gap(3);
      // T5 ADDC back-to-back with start held and inputs changing while busy
      issue(2'b10, 2'd2, 2'd1, 1'b1);
      issue(2'b10, 2'd0, 2'd2, 1'b1);
      issue(2'b01, 2'd2, 2'd2, 1'b1);
      issue(2'b11, 2'd2, 2'd2, 1'b1);
      issue(2'b00, 2'd0, 2'd1, 1'b1);
      gap(1);
      // T6 Clear in the middle of a MUL EXEC
      issue(2'b01, 2'd1, 2'd0, 1'b0);
      @(posedge CK); #1;
      Clear = 1'b1;
      @(posedge CK); #1;
      Clear = 1'b0;
      next_free = edges + 1;
      gap(2);
      // Random traffic; at least 256 legal instructions so the count wraps
      while (legal_after_clear < 300) begin
         ro = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         rs = ($urandom_range(0, 14) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         rd = ($urandom_range(0, 14) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         if (ro != 2'd3 && rs != 2'd3 && rd != 2'd3) legal_after_clear++;
         issue(ro, rs, rd, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
      end
      gap(1);
      guard = 0;
      while (q.size() != 0 && guard < 200) begin
         @(negedge CK);
         guard++;
      end
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain got %0d outstanding instructions want 0", q.size());
      end
      gap(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
